slave_port_arbiter: RTL and testbench

- Upstream neighbour of the crossbar Slave: one instance per slave port.
- Accepts request/cmd/wdata from pN masters and grants one master at a time, round-robin.
- Drives the single slave-side req/cmd/wdata interface and routes the slave's ack and read data back to the granted master.
- Adds a response timeout so a master is never stalled forever by a slave that is still in its initialisation delay or is otherwise unresponsive.

---
 rtl/crossbar_pkg.sv | 16 +
 rtl/slave_port_arbiter_rr_pick.sv | 33 +++
 rtl/slave_port_arbiter.sv | 135 +++++++++++++
 tb/tb_slave_port_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// Shared crossbar definitions: data width, command encoding and the
// per-slave-port arbiter state type.
package crossbar_pkg;

    localparam int DATA_W = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } arb_state_t;

endpackage

// File: rtl/slave_port_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or above ptr,
// wrapping, found by a priority search over the request vector laid out twice.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;

    always_comb begin
        dbl    = {req, req};
        masked = '0;
        grant  = '0;
        valid  = 1'b0;
        // Bits below ptr in the lower copy are masked; the upper copy supplies the wrap.
        for (int i = 0; i < 2*N; i++) begin
            if (i >= int'(ptr)) masked[i] = dbl[i];
        end
        for (int i = 0; i < 2*N; i++) begin
            if (masked[i] && !valid) begin
                valid        = 1'b1;
                grant[i % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slave_port_arbiter.sv
// Per-slave-port arbiter: round-robin grant among pN masters, one outstanding
// transaction to the slave, with a response timeout producing an error completion.
module slave_port_arbiter
    import crossbar_pkg::*;
#(
    parameter int pN       = 4,
    parameter int pTimeout = 255
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic [pN-1:0]        master_req,
    input  logic [pN-1:0]        master_cmd,
    input  logic [pN*DATA_W-1:0] master_wdata,
    output logic [pN-1:0]        master_ack,
    output logic                 master_err,
    output logic [DATA_W-1:0]    master_rdata,
    output logic                 slave_req,
    output logic                 slave_cmd,
    output logic [DATA_W-1:0]    slave_wdata,
    input  logic                 slave_ack,
    input  logic [DATA_W-1:0]    slave_rdata,
    output logic [pN-1:0]        oGrant
);

    localparam int PW = $clog2(pN);
    localparam int CW = $clog2(pTimeout + 1);

    arb_state_t              state, state_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic [PW-1:0]           ptr, ptr_d;
    logic [PW-1:0]           gidx, gidx_d;
    logic [pN-1:0]           grant_d, ack_d;
    logic                    err_d, sreq_d, scmd_d;
    logic [DATA_W-1:0]       rdata_d, swd_d;

    logic [pN-1:0]           pick_grant;
    logic                    pick_valid;
    logic [PW-1:0]           pick_idx;
    logic [pN-1:0][DATA_W-1:0] wd_arr;

    assign wd_arr = master_wdata;

    rr_pick #(.N(pN), .PW(PW)) u_pick (
        .req   (master_req),
        .ptr   (ptr),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < pN; i++) begin
            if (pick_grant[i]) pick_idx = PW'(i);
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ptr_d   = ptr;
        gidx_d  = gidx;
        grant_d = oGrant;
        sreq_d  = slave_req;
        scmd_d  = slave_cmd;
        swd_d   = slave_wdata;
        ack_d   = '0;
        err_d   = 1'b0;
        rdata_d = master_rdata;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ISSUE;
                    gidx_d  = pick_idx;
                    grant_d = pick_grant;
                    sreq_d  = 1'b1;
                    scmd_d  = master_cmd[pick_idx];
                    swd_d   = wd_arr[pick_idx];
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                if (slave_ack) begin
                    sreq_d  = 1'b0;
                    ack_d   = oGrant;
                    if (slave_cmd == CMD_READ) rdata_d = slave_rdata;
                    state_d = DONE;
                end else if (cnt == CW'(pTimeout - 1)) begin
                    sreq_d  = 1'b0;
                    ack_d   = oGrant;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DONE: begin
                // slave_cmd/slave_wdata held: the slave samples write data a cycle after its ack.
                ptr_d   = (gidx == PW'(pN - 1)) ? '0 : gidx + 1'b1;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            ptr          <= '0;
            gidx         <= '0;
            oGrant       <= '0;
            slave_req    <= 1'b0;
            slave_cmd    <= 1'b0;
            slave_wdata  <= '0;
            master_ack   <= '0;
            master_err   <= 1'b0;
            master_rdata <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            ptr          <= ptr_d;
            gidx         <= gidx_d;
            oGrant       <= grant_d;
            slave_req    <= sreq_d;
            slave_cmd    <= scmd_d;
            slave_wdata  <= swd_d;
            master_ack   <= ack_d;
            master_err   <= err_d;
            master_rdata <= rdata_d;
        end
    end

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected completions, monitors pop and compare
// on every master_ack. A second instance with a short timeout covers the error path.
module tb_slave_port_arbiter;

    typedef struct {
        int          idx;
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        cmd;
        logic [31:0] wdata;
        int          cyc;
    } exp_t;

    logic iClk = 1'b0;
    logic iRst_n = 1'b0;
    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // main instance
    logic [3:0]   m_req = '0, m_cmd = '0;
    logic [127:0] m_wdata = '0;
    logic [3:0]   m_ack, m_grant;
    logic         m_err, s_req, s_cmd;
    logic [31:0]  m_rdata, s_wdata;
    logic         s_ack;
    logic [31:0]  s_rdata;

    // timeout instance, slave never answers
    logic [3:0]   t_req = '0, t_cmd = '0;
    logic [127:0] t_wdata = '0;
    logic [3:0]   t_ack, t_grant;
    logic         t_err, t_sreq, t_scmd;
    logic [31:0]  t_rdata, t_swdata;
    logic         t_sack = 1'b0;
    logic [31:0]  t_srdata = 32'hFFFF_FFFF;

    slave_port_arbiter #(.pN(4), .pTimeout(255)) u_dut (
        .iClk(iClk), .iRst_n(iRst_n),
        .master_req(m_req), .master_cmd(m_cmd), .master_wdata(m_wdata),
        .master_ack(m_ack), .master_err(m_err), .master_rdata(m_rdata),
        .slave_req(s_req), .slave_cmd(s_cmd), .slave_wdata(s_wdata),
        .slave_ack(s_ack), .slave_rdata(s_rdata), .oGrant(m_grant)
    );

    slave_port_arbiter #(.pN(4), .pTimeout(16)) u_dut_to (
        .iClk(iClk), .iRst_n(iRst_n),
        .master_req(t_req), .master_cmd(t_cmd), .master_wdata(t_wdata),
        .master_ack(t_ack), .master_err(t_err), .master_rdata(t_rdata),
        .slave_req(t_sreq), .slave_cmd(t_scmd), .slave_wdata(t_swdata),
        .slave_ack(t_sack), .slave_rdata(t_srdata), .oGrant(t_grant)
    );

    // slave model: acks one cycle after req when ready, stores write data a cycle after ack
    logic        slave_ready = 1'b1;
    logic        s_ack_d;
    logic [31:0] mem = '0;
    always @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            s_ack   <= 1'b0;
            s_ack_d <= 1'b0;
            s_rdata <= '0;
        end else begin
            s_ack   <= s_req && !s_ack && slave_ready;
            s_ack_d <= s_ack;
            s_rdata <= mem;
            if (s_ack_d && s_cmd) mem <= s_wdata;
        end
    end

    exp_t q[$];
    exp_t tq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input string tag, inout exp_t qq[$], input logic [3:0] ack,
                       input logic err, input logic [31:0] rd, input logic cmd,
                       input logic [31:0] wd);
        exp_t e;
        if (qq.size() == 0) begin
            chk({tag, "_unexpected_ack"}, {28'd0, ack}, 32'd0);
        end else begin
            e = qq.pop_front();
            chk({tag, "_ack_grant"}, {28'd0, ack}, 32'(1 << e.idx));
            chk({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
            if (e.chk_rd) chk({tag, "_rdata"}, rd, e.rdata);
            chk({tag, "_slave_cmd"}, {31'd0, cmd}, {31'd0, e.cmd});
            chk({tag, "_slave_wdata"}, wd, e.wdata);
            if (e.cyc >= 0) chk({tag, "_ack_cycle"}, 32'(cyc), 32'(e.cyc));
        end
    endtask

    always @(negedge iClk) begin
        if (iRst_n && m_ack != 0) mon("main", q, m_ack, m_err, m_rdata, s_cmd, s_wdata);
        if (iRst_n && t_ack != 0) mon("tmo", tq, t_ack, t_err, t_rdata, t_scmd, t_swdata);
    end

    task automatic push(input logic to, input int idx, input logic err, input logic chk_rd,
                        input logic [31:0] rd, input logic cmd, input logic [31:0] wd,
                        input int c);
        exp_t e;
        e.idx = idx; e.err = err; e.chk_rd = chk_rd; e.rdata = rd;
        e.cmd = cmd; e.wdata = wd; e.cyc = c;
        if (to) tq.push_back(e);
        else    q.push_back(e);
    endtask

    // masters drop req on the edge after their ack
    task automatic step();
        @(negedge iClk);
        m_req = m_req & ~m_ack;
        t_req = t_req & ~t_ack;
    endtask

    task automatic issue(input int i, input logic cmd, input logic [31:0] wd);
        m_req[i] = 1'b1;
        m_cmd[i] = cmd;
        m_wdata[32*i +: 32] = wd;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || tq.size() != 0) && n < 200) begin
            step();
            n++;
        end
        step();
        checks++;
        if (q.size() != 0 || tq.size() != 0) begin
            failures++;
            $display("FAIL drain_bound pending=%0d expected=0", q.size() + tq.size());
            q.delete();
            tq.delete();
        end
    endtask

    initial begin
        int c;
        // reset / idle
        repeat (3) @(negedge iClk);
        chk("rst_slave_req", {31'd0, s_req}, 32'd0);
        chk("rst_grant", {28'd0, m_grant}, 32'd0);
        chk("rst_ack", {28'd0, m_ack}, 32'd0);
        iRst_n = 1'b1;
        repeat (4) begin
            step();
            chk("idle_slave_req", {31'd0, s_req}, 32'd0);
            chk("idle_grant", {28'd0, m_grant}, 32'd0);
        end

        // contention from pointer 0: order 0, 2, 3, four cycles apart
        c = cyc;
        issue(0, 1'b1, 32'h1111_0000);
        issue(2, 1'b1, 32'h2222_0002);
        issue(3, 1'b1, 32'h3333_0003);
        push(0, 0, 0, 0, 0, 1'b1, 32'h1111_0000, c + 3);
        push(0, 2, 0, 0, 0, 1'b1, 32'h2222_0002, c + 7);
        push(0, 3, 0, 0, 0, 1'b1, 32'h3333_0003, c + 11);
        drain();

        // write then read on master 1, latency checked
        c = cyc;
        issue(1, 1'b1, 32'hDEAD_BEEF);
        push(0, 1, 0, 0, 0, 1'b1, 32'hDEAD_BEEF, c + 3);
        step();
        chk("lat_slave_req", {31'd0, s_req}, 32'd1);
        chk("lat_grant", {28'd0, m_grant}, 32'h2);
        drain();
        c = cyc;
        issue(1, 1'b0, 32'h0);
        push(0, 1, 0, 1, 32'hDEAD_BEEF, 1'b0, 32'h0, c + 3);
        drain();

        // slave busy for 50 cycles: request waits, then completes cleanly
        slave_ready = 1'b0;
        issue(2, 1'b0, 32'h0);
        push(0, 2, 0, 1, 32'hDEAD_BEEF, 1'b0, 32'h0, -1);
        repeat (50) step();
        chk("init_slave_req_held", {31'd0, s_req}, 32'd1);
        chk("init_grant_held", {28'd0, m_grant}, 32'h4);
        slave_ready = 1'b1;
        drain();

        // master 0 write leaves the pointer at 1
        issue(0, 1'b1, 32'hA5A5_A5A5);
        push(0, 0, 0, 0, 0, 1'b1, 32'hA5A5_A5A5, -1);
        drain();

        // reset while master 1 is in ISSUE
        slave_ready = 1'b0;
        issue(1, 1'b0, 32'h0);
        repeat (3) step();
        chk("pre_rst_grant", {28'd0, m_grant}, 32'h2);
        #2 iRst_n = 1'b0;
        m_req = '0;
        #1;
        chk("async_rst_slave_req", {31'd0, s_req}, 32'd0);
        chk("async_rst_grant", {28'd0, m_grant}, 32'd0);
        chk("async_rst_ack", {28'd0, m_ack}, 32'd0);
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        slave_ready = 1'b1;
        step();
        c = cyc;
        issue(0, 1'b0, 32'h0);
        issue(1, 1'b0, 32'h0);
        push(0, 0, 0, 1, 32'hA5A5_A5A5, 1'b0, 32'h0, c + 3);
        push(0, 1, 0, 1, 32'hA5A5_A5A5, 1'b0, 32'h0, c + 7);
        drain();

        // timeout instance: ack with err=1 and rdata=0, sixteen cycles into ISSUE
        c = cyc;
        t_req[3] = 1'b1;
        t_cmd[3] = 1'b0;
        t_wdata[127:96] = 32'h1234_5678;
        push(1, 3, 1, 1, 32'h0, 1'b0, 32'h1234_5678, c + 17);
        repeat (8) step();
        chk("tmo_slave_req_held", {31'd0, t_sreq}, 32'd1);
        drain();
        t_sack = 1'b1;
        repeat (3) step();
        t_sack = 1'b0;
        repeat (3) step();
        chk("stray_ack_slave_req", {31'd0, t_sreq}, 32'd0);
        chk("stray_ack_grant", {28'd0, t_grant}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
